serdes_noise_injector: RTL

- Synthesizable error injector placed between eth_phy_10g serdes_tx_data/serdes_tx_hdr and serdes_rx_data/serdes_rx_hdr in loopback benches and FPGA link-stress builds.
- Corrupts 64b/66b blocks at a programmable probability, using an on-chip LFSR compared against a threshold.
- Supports three modes: header-only, single data-bit flip, and header bursts.
- Runs for a programmed number of blocks and keeps saturating statistics counters for BER checks against rx_error_count / rx_high_ber.

---
 rtl/serdes_noise_injector.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serdes_noise_injector.sv
// rtl/serdes_noise_injector.sv - 64b/66b block error injector with LFSR hit draw, burst mode and run statistics
module serdes_noise_injector #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          HDR_WIDTH   = 2,
    parameter logic [31:0] LFSR_SEED   = 32'h1,
    parameter int          BURST_WIDTH = 8,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [HDR_WIDTH-1:0]   in_hdr,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [HDR_WIDTH-1:0]   out_hdr,
    input  logic [1:0]             cfg_mode,
    input  logic [31:0]            cfg_threshold,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    input  logic [COUNT_WIDTH-1:0] cfg_total_blocks,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] stat_blocks,
    output logic [COUNT_WIDTH-1:0] stat_err_blocks,
    output logic [COUNT_WIDTH-1:0] stat_bit_flips
);

    localparam int          IDX_W     = $clog2(DATA_WIDTH);
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST, S_DONE} state_t;

    state_t                 state, state_nx;
    logic [31:0]            lfsr;
    logic [DATA_WIDTH-1:0]  data_q, data_nx, flip_mask;
    logic [HDR_WIDTH-1:0]   hdr_q, hdr_nx, hdr_bad;
    logic [COUNT_WIDTH-1:0] blocks_q, blocks_nx, blk_inc;
    logic [COUNT_WIDTH-1:0] err_q, err_nx, flips_q, flips_nx;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_nx, burst_eff;
    logic                   hit, reach_total;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + COUNT_WIDTH'(1);
    endfunction

    always_comb begin
        hit          = (lfsr < cfg_threshold) || (cfg_threshold == 32'hFFFFFFFF);
        burst_eff    = (cfg_burst_len == '0) ? BURST_WIDTH'(1) : cfg_burst_len;
        blk_inc      = sat_inc(blocks_q);
        reach_total  = (cfg_total_blocks != '0) && (blk_inc == cfg_total_blocks);
        flip_mask    = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << lfsr[IDX_W-1:0];
        // Replicating the top header bit always yields 00 or 11, never a valid sync header.
        hdr_bad      = {HDR_WIDTH{in_hdr[HDR_WIDTH-1]}};

        state_nx     = state;
        data_nx      = in_data;
        hdr_nx       = in_hdr;
        blocks_nx    = blocks_q;
        err_nx       = err_q;
        flips_nx     = flips_q;
        remaining_nx = remaining_q;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nx  = S_RUN;
                    blocks_nx = '0;
                    err_nx    = '0;
                    flips_nx  = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nx = S_IDLE;
                end else begin
                    blocks_nx = blk_inc;
                    if (hit && cfg_mode != 2'd0) begin
                        err_nx = sat_inc(err_q);
                        if (cfg_mode == 2'd2) begin
                            data_nx  = in_data ^ flip_mask;
                            flips_nx = sat_inc(flips_q);
                        end else begin
                            hdr_nx = hdr_bad;
                        end
                    end
                    if (reach_total) begin
                        state_nx = S_DONE;
                    end else if (cfg_mode == 2'd3 && hit && burst_eff > BURST_WIDTH'(1)) begin
                        state_nx     = S_BURST;
                        remaining_nx = burst_eff - BURST_WIDTH'(1);
                    end
                end
            end
            S_BURST: begin
                if (stop) begin
                    state_nx = S_IDLE;
                end else begin
                    hdr_nx       = hdr_bad;
                    err_nx       = sat_inc(err_q);
                    blocks_nx    = blk_inc;
                    remaining_nx = remaining_q - BURST_WIDTH'(1);
                    if (reach_total) begin
                        state_nx = S_DONE;
                    end else if (remaining_q == BURST_WIDTH'(1)) begin
                        state_nx = S_RUN;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lfsr        <= LFSR_SEED;
            data_q      <= '0;
            hdr_q       <= '0;
            blocks_q    <= '0;
            err_q       <= '0;
            flips_q     <= '0;
            remaining_q <= '0;
        end else begin
            state       <= state_nx;
            lfsr        <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
            data_q      <= data_nx;
            hdr_q       <= hdr_nx;
            blocks_q    <= blocks_nx;
            err_q       <= err_nx;
            flips_q     <= flips_nx;
            remaining_q <= remaining_nx;
        end
    end

    assign out_data        = data_q;
    assign out_hdr         = hdr_q;
    assign busy            = (state == S_RUN) || (state == S_BURST);
    assign done            = (state == S_DONE);
    assign stat_blocks     = blocks_q;
    assign stat_err_blocks = err_q;
    assign stat_bit_flips  = flips_q;

endmodule
